result_collector: RTL

- Drain-side counterpart of the systolic-array scheduler: accepts the skewed per-column result streams leaving the bottom row of PEs after the scheduler enables multiplication.
- Deskews the streams into full result-matrix rows and presents them on a valid/ready output port.
- Signals completion once all MATRIX_SIZE rows have been handed off.
- Sits between the PE array and the result writeback logic.

---
 rtl/result_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/result_collector.sv
// Drain-side collector for the systolic array: deskews per-column result streams
// into full rows, hands them off on a valid/ready port and flags completion.
module result_collector #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [MATRIX_SIZE-1:0]           col_valid,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data,
  output logic [$clog2(MATRIX_SIZE):0]     out_row,
  output logic                             done,
  output logic                             error
);

  localparam int CW = $clog2(MATRIX_SIZE) + 1;
  localparam int PW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] N_C     = CW'(MATRIX_SIZE);
  localparam logic [CW-1:0] LAST_C  = CW'(MATRIX_SIZE - 1);
  localparam logic [PW-1:0] PZERO_C = PW'(0);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [PW-1:0] PLAST_C = PW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic [DATA_SIZE-1:0] mem_r   [MATRIX_SIZE][MATRIX_SIZE];
  logic [PW-1:0]        wr_ptr_r[MATRIX_SIZE];
  logic [PW-1:0]        rd_ptr_r[MATRIX_SIZE];
  logic [CW-1:0]        fill_r  [MATRIX_SIZE];
  logic [CW-1:0]        acc_r   [MATRIX_SIZE];
  logic [CW-1:0]        row_r;
  logic                 err_r;

  logic [MATRIX_SIZE-1:0]           push_s;
  logic                             out_valid_s;
  logic                             pop_s;
  logic                             viol_s;
  logic                             clear_s;
  logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PLAST_C) ? PZERO_C : p + PONE_C;
  endfunction

  // Row availability, handshake, per-column push qualification and protocol checks
  always_comb begin
    out_valid_s = (state_r == ST_COLLECT);
    for (int j = 0; j < MATRIX_SIZE; j++) begin
      out_valid_s = out_valid_s & (fill_r[j] != ZERO_C);
    end
    pop_s = out_valid_s & out_ready;
    for (int j = 0; j < MATRIX_SIZE; j++) begin
      // A full FIFO can still take an element when the row drains in the same cycle
      push_s[j] = col_valid[j] && (state_r == ST_COLLECT) && (acc_r[j] != N_C) &&
                  ((fill_r[j] != N_C) || pop_s);
    end
    viol_s  = |(col_valid & ~push_s);
    clear_s = start && (state_r != ST_COLLECT);
  end

  // Row presented to writeback: concatenation of the column FIFO heads
  always_comb begin
    out_data_s = '0;
    for (int j = 0; j < MATRIX_SIZE; j++) begin
      out_data_s[j*DATA_SIZE +: DATA_SIZE] = mem_r[j][rd_ptr_r[j]];
    end
  end

  // Next-state decode for the collection FSM
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_COLLECT;
        else       state_next_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (pop_s && (row_r == LAST_C)) state_next_s = ST_DONE;
        else                            state_next_s = ST_COLLECT;
      end
      ST_DONE: begin
        if (start) state_next_s = ST_COLLECT;
        else       state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Column FIFOs, element/row counters and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        for (int k = 0; k < MATRIX_SIZE; k++) mem_r[j][k] <= '0;
        wr_ptr_r[j] <= PZERO_C;
        rd_ptr_r[j] <= PZERO_C;
        fill_r[j]   <= ZERO_C;
        acc_r[j]    <= ZERO_C;
      end
      row_r <= ZERO_C;
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | viol_s;
      if (clear_s) begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
          wr_ptr_r[j] <= PZERO_C;
          rd_ptr_r[j] <= PZERO_C;
          fill_r[j]   <= ZERO_C;
          acc_r[j]    <= ZERO_C;
        end
        row_r <= ZERO_C;
      end else begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
          if (push_s[j]) begin
            mem_r[j][wr_ptr_r[j]] <= col_data[j*DATA_SIZE +: DATA_SIZE];
            wr_ptr_r[j]           <= next_ptr(wr_ptr_r[j]);
            acc_r[j]              <= acc_r[j] + ONE_C;
          end else begin
            acc_r[j] <= acc_r[j];
          end
          if (pop_s) rd_ptr_r[j] <= next_ptr(rd_ptr_r[j]);
          else       rd_ptr_r[j] <= rd_ptr_r[j];
          case ({push_s[j], pop_s})
            2'b10:   fill_r[j] <= fill_r[j] + ONE_C;
            2'b01:   fill_r[j] <= fill_r[j] - ONE_C;
            default: fill_r[j] <= fill_r[j];
          endcase
        end
        if (pop_s) row_r <= row_r + ONE_C;
        else       row_r <= row_r;
      end
    end
  end

  assign out_valid = out_valid_s;
  assign out_data  = out_data_s;
  assign out_row   = row_r;
  assign done      = (state_r == ST_DONE);
  assign error     = err_r;

endmodule
